pcie_mm_initiator: RTL and testbench

Bus master for the internal MM register bus. It drives the address-decoder input side (ADDR/WR_EN/RD_EN/WR_DATA) and collects RD_DATA/RD_DATA_V. Requests come from the PCIe application RX path on a valid/ready interface. Read completions, tagged for completion-TLP generation, go back on a valid/ready interface. The block allows one outstanding read, unlimited back-to-back writes, and a read timeout so a dead target cannot hang the PCIe link.

---
 rtl/pcie_mm_initiator.sv | 149 ++++++++++++++
 tb/tb_pcie_mm_initiator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_mm_initiator.sv
// pcie_mm_initiator: MM register bus master for the PCIe RX request path.
// One outstanding read with timeout, back-to-back writes, tagged completions.
module pcie_mm_initiator #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [DATA_W-1:0] cpl_data,
    output logic [TAG_W-1:0]  cpl_tag,
    output logic              cpl_timeout,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [DATA_W-1:0] oMM_WR_DATA,
    input  logic [DATA_W-1:0] iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,
    output logic              busy,
    output logic [15:0]       timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        CPL
    } state_e;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mm_addr_q, mm_addr_d;
    logic              mm_wr_en_q, mm_wr_en_d;
    logic              mm_rd_en_q, mm_rd_en_d;
    logic [DATA_W-1:0] mm_wdata_q, mm_wdata_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [15:0]       wait_q, wait_d;
    logic [DATA_W-1:0] cpl_data_q, cpl_data_d;
    logic              cpl_to_q, cpl_to_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] to_pat;

    // Timeout pattern marks the dead address so software can identify it
    assign to_pat = DATA_W'({32'hBAD0_BAD0, 32'(rd_addr_q)});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mm_addr_q  <= '0;
            mm_wr_en_q <= 1'b0;
            mm_rd_en_q <= 1'b0;
            mm_wdata_q <= '0;
            rd_addr_q  <= '0;
            tag_q      <= '0;
            wait_q     <= '0;
            cpl_data_q <= '0;
            cpl_to_q   <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            mm_addr_q  <= mm_addr_d;
            mm_wr_en_q <= mm_wr_en_d;
            mm_rd_en_q <= mm_rd_en_d;
            mm_wdata_q <= mm_wdata_d;
            rd_addr_q  <= rd_addr_d;
            tag_q      <= tag_d;
            wait_q     <= wait_d;
            cpl_data_q <= cpl_data_d;
            cpl_to_q   <= cpl_to_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mm_addr_d  = mm_addr_q;
        mm_wr_en_d = 1'b0;
        mm_rd_en_d = 1'b0;
        mm_wdata_d = mm_wdata_q;
        rd_addr_d  = rd_addr_q;
        tag_d      = tag_q;
        wait_d     = wait_q;
        cpl_data_d = cpl_data_q;
        cpl_to_d   = cpl_to_q;
        to_cnt_d   = to_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mm_addr_d = req_addr;
                    if (req_wr) begin
                        mm_wr_en_d = 1'b1;
                        mm_wdata_d = req_wdata;
                    end else begin
                        mm_rd_en_d = 1'b1;
                        rd_addr_d  = req_addr;
                        tag_d      = req_tag;
                        wait_d     = '0;
                        state_d    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                wait_d = wait_q + 16'd1;
                // Data arriving on the timeout cycle still wins
                if (iMM_RD_DATA_V) begin
                    cpl_data_d = iMM_RD_DATA;
                    cpl_to_d   = 1'b0;
                    state_d    = CPL;
                end else if (wait_q == WAIT_LAST) begin
                    cpl_data_d = to_pat;
                    cpl_to_d   = 1'b1;
                    if (to_cnt_q != 16'hFFFF) begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                    state_d = CPL;
                end
            end
            CPL: begin
                if (cpl_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign cpl_valid   = (state_q == CPL);
    assign cpl_data    = cpl_data_q;
    assign cpl_tag     = tag_q;
    assign cpl_timeout = cpl_to_q;
    assign oMM_ADDR    = mm_addr_q;
    assign oMM_WR_EN   = mm_wr_en_q;
    assign oMM_RD_EN   = mm_rd_en_q;
    assign oMM_WR_DATA = mm_wdata_q;
    assign timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_pcie_mm_initiator.sv
// tb_pcie_mm_initiator: directed checks for the MM bus initiator.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pcie_mm_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [16:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_tag;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [63:0] cpl_data;
    logic [7:0]  cpl_tag;
    logic        cpl_timeout;
    logic [16:0] oMM_ADDR;
    logic        oMM_WR_EN;
    logic        oMM_RD_EN;
    logic [63:0] oMM_WR_DATA;
    logic [63:0] iMM_RD_DATA;
    logic        iMM_RD_DATA_V;
    logic        busy;
    logic [15:0] timeout_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pcie_mm_initiator #(
        .ADDR_W (17),
        .DATA_W (64),
        .TAG_W  (8),
        .TIMEOUT(255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_tag      (req_tag),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_data     (cpl_data),
        .cpl_tag      (cpl_tag),
        .cpl_timeout  (cpl_timeout),
        .oMM_ADDR     (oMM_ADDR),
        .oMM_WR_EN    (oMM_WR_EN),
        .oMM_RD_EN    (oMM_RD_EN),
        .oMM_WR_DATA  (oMM_WR_DATA),
        .iMM_RD_DATA  (iMM_RD_DATA),
        .iMM_RD_DATA_V(iMM_RD_DATA_V),
        .busy         (busy),
        .timeout_cnt  (timeout_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_addr"}, 64'(oMM_ADDR), 64'h0);
        chk({tag, "_wren"}, 64'(oMM_WR_EN), 64'h0);
        chk({tag, "_rden"}, 64'(oMM_RD_EN), 64'h0);
        chk({tag, "_wdat"}, oMM_WR_DATA, 64'h0);
        chk({tag, "_cplv"}, 64'(cpl_valid), 64'h0);
        chk({tag, "_cpld"}, cpl_data, 64'h0);
        chk({tag, "_cplt"}, 64'(cpl_tag), 64'h0);
        chk({tag, "_cplto"}, 64'(cpl_timeout), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_tocnt"}, 64'(timeout_cnt), 64'h0);
        chk({tag, "_rdy"}, 64'(req_ready), 64'h1);
    endtask

    task automatic set_req(input logic wr, input logic [16:0] a,
                           input logic [63:0] d, input logic [7:0] t);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_tag   = t;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_wr        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_tag       = '0;
        cpl_ready     = 1'b0;
        iMM_RD_DATA   = '0;
        iMM_RD_DATA_V = 1'b0;
        repeat (3) tick();
        chk_idle_zero("rst");
        rst_n = 1'b1;
        tick();

        // single write
        set_req(1'b1, 17'h00010, 64'h1122334455667788, 8'h00);
        chk("w1_rdy", 64'(req_ready), 64'h1);
        tick();
        req_valid = 1'b0;
        chk("w1_wren", 64'(oMM_WR_EN), 64'h1);
        chk("w1_rden", 64'(oMM_RD_EN), 64'h0);
        chk("w1_addr", 64'(oMM_ADDR), 64'h10);
        chk("w1_data", oMM_WR_DATA, 64'h1122334455667788);
        chk("w1_cplv", 64'(cpl_valid), 64'h0);
        tick();
        chk("w1_wren_off", 64'(oMM_WR_EN), 64'h0);
        chk("w1_addr_hold", 64'(oMM_ADDR), 64'h10);
        chk("w1_cplv2", 64'(cpl_valid), 64'h0);

        // four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 17'h00100 + 17'(i), 64'hA0 + 64'(i), 8'h00);
            chk("bb_rdy", 64'(req_ready), 64'h1);
            tick();
            chk("bb_wren", 64'(oMM_WR_EN), 64'h1);
            chk("bb_addr", 64'(oMM_ADDR), 64'h100 + 64'(i));
            chk("bb_data", oMM_WR_DATA, 64'hA0 + 64'(i));
        end
        req_valid = 1'b0;
        tick();
        chk("bb_wren_off", 64'(oMM_WR_EN), 64'h0);

        // read, response at +3 after strobe, consumer ready
        cpl_ready = 1'b1;
        set_req(1'b0, 17'h04000, 64'h0, 8'h5A);
        tick();
        req_valid = 1'b0;
        chk("r1_rden", 64'(oMM_RD_EN), 64'h1);
        chk("r1_wren", 64'(oMM_WR_EN), 64'h0);
        chk("r1_addr", 64'(oMM_ADDR), 64'h4000);
        chk("r1_busy", 64'(busy), 64'h1);
        chk("r1_rdy", 64'(req_ready), 64'h0);
        tick();
        chk("r1_rden_off", 64'(oMM_RD_EN), 64'h0);
        tick();
        tick();
        iMM_RD_DATA   = 64'hCAFE;
        iMM_RD_DATA_V = 1'b1;
        chk("r1_cplv_early", 64'(cpl_valid), 64'h0);
        tick();
        iMM_RD_DATA_V = 1'b0;
        chk("r1_cplv", 64'(cpl_valid), 64'h1);
        chk("r1_data", cpl_data, 64'hCAFE);
        chk("r1_tag", 64'(cpl_tag), 64'h5A);
        chk("r1_to", 64'(cpl_timeout), 64'h0);
        tick();
        chk("r1_cplv_off", 64'(cpl_valid), 64'h0);
        chk("r1_idle", 64'(busy), 64'h0);
        chk("r1_rdy2", 64'(req_ready), 64'h1);

        // read with no responder times out
        cpl_ready = 1'b0;
        set_req(1'b0, 17'h1FFFF, 64'h0, 8'h33);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!cpl_valid && n < 400) begin
            tick();
            n++;
        end
        chk("to_lat", 64'(n), 64'd256);
        chk("to_cplv", 64'(cpl_valid), 64'h1);
        chk("to_data", cpl_data, 64'hBAD0BAD0_0001FFFF);
        chk("to_flag", 64'(cpl_timeout), 64'h1);
        chk("to_tag", 64'(cpl_tag), 64'h33);
        chk("to_cnt", 64'(timeout_cnt), 64'h1);
        chk("to_rdy", 64'(req_ready), 64'h0);
        iMM_RD_DATA   = 64'hDEAD;
        iMM_RD_DATA_V = 1'b1;
        tick();
        iMM_RD_DATA_V = 1'b0;
        chk("late_data", cpl_data, 64'hBAD0BAD0_0001FFFF);
        chk("late_flag", 64'(cpl_timeout), 64'h1);
        chk("late_cplv", 64'(cpl_valid), 64'h1);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk("to_cplv_off", 64'(cpl_valid), 64'h0);
        iMM_RD_DATA_V = 1'b1;
        tick();
        iMM_RD_DATA_V = 1'b0;
        chk("late_idle_busy", 64'(busy), 64'h0);
        chk("late_idle_cplv", 64'(cpl_valid), 64'h0);
        chk("late_idle_cnt", 64'(timeout_cnt), 64'h1);

        // completion back-pressured while a write waits
        set_req(1'b0, 17'h00020, 64'h0, 8'hA5);
        tick();
        set_req(1'b1, 17'h00055, 64'h5555, 8'h00);
        tick();
        tick();
        tick();
        iMM_RD_DATA   = 64'h0123456789ABCDEF;
        iMM_RD_DATA_V = 1'b1;
        tick();
        iMM_RD_DATA_V = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_cplv", 64'(cpl_valid), 64'h1);
            chk("bp_data", cpl_data, 64'h0123456789ABCDEF);
            chk("bp_tag", 64'(cpl_tag), 64'hA5);
            chk("bp_to", 64'(cpl_timeout), 64'h0);
            chk("bp_rdy", 64'(req_ready), 64'h0);
            chk("bp_wren", 64'(oMM_WR_EN), 64'h0);
            tick();
        end
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk("bp_cplv_off", 64'(cpl_valid), 64'h0);
        chk("bp_rdy_back", 64'(req_ready), 64'h1);
        chk("bp_wren_pre", 64'(oMM_WR_EN), 64'h0);
        tick();
        req_valid = 1'b0;
        chk("bp_wren", 64'(oMM_WR_EN), 64'h1);
        chk("bp_waddr", 64'(oMM_ADDR), 64'h55);
        chk("bp_wdata", oMM_WR_DATA, 64'h5555);
        tick();

        // reset in the middle of a read
        set_req(1'b0, 17'h00300, 64'h0, 8'h11);
        tick();
        req_valid = 1'b0;
        tick();
        chk("mr_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("mr");
        tick();
        rst_n = 1'b1;
        tick();
        cpl_ready = 1'b1;
        set_req(1'b0, 17'h00400, 64'h0, 8'h22);
        tick();
        req_valid = 1'b0;
        chk("pr_rden", 64'(oMM_RD_EN), 64'h1);
        chk("pr_addr", 64'(oMM_ADDR), 64'h400);
        tick();
        tick();
        tick();
        iMM_RD_DATA   = 64'h77;
        iMM_RD_DATA_V = 1'b1;
        tick();
        iMM_RD_DATA_V = 1'b0;
        chk("pr_cplv", 64'(cpl_valid), 64'h1);
        chk("pr_data", cpl_data, 64'h77);
        chk("pr_tag", 64'(cpl_tag), 64'h22);
        chk("pr_to", 64'(cpl_timeout), 64'h0);
        tick();
        chk("pr_cplv_off", 64'(cpl_valid), 64'h0);
        chk("pr_idle", 64'(busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
